frequency_dump_sequencer: RTL and testbench



---
 rtl/freq_dump_pkg.sv | 20 ++
 rtl/freq_window_timer.sv | 35 +++
 rtl/frequency_dump_sequencer.sv | 133 +++++++++++++
 tb/tb_frequency_dump_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_dump_pkg.sv
// Shared constants for the frequency dump sequencer: state encoding,
// dump header magic and frame counter width.
package freq_dump_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CLEAR    = 3'd1;
   localparam logic [2:0] ST_MEASURE  = 3'd2;
   localparam logic [2:0] ST_SNAPSHOT = 3'd3;
   localparam logic [2:0] ST_DUMP     = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam int         FRAME_W   = 16;

   function automatic logic [31:0] header_word(input logic [FRAME_W-1:0] frame,
                                               input logic [7:0]         npix);
      return {frame, npix, HDR_MAGIC};
   endfunction

endpackage

// File: rtl/freq_window_timer.sv
// Measurement window counter: cleared by load, counts 0..WINDOW_CYCLES-1
// while run is high and flags the terminal count.
module freq_window_timer
   import freq_dump_pkg::*;
#(
   parameter int WINDOW_CYCLES = 100000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic tc
);

   localparam int               CNT_W = $clog2(WINDOW_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW_CYCLES - 1);

   logic [CNT_W-1:0] count_r;

   // window counter; holds at terminal count until the sequencer leaves MEASURE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= '0;
      end else if (run && (count_r != LAST)) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = run && (count_r == LAST);

endmodule

// File: rtl/frequency_dump_sequencer.sv
// Clear / measure / snapshot / dump sequencer for the analyzer bank.
// Define FREQ_DUMP_HEADER_EN to prefix each dump with a frame header word.
module frequency_dump_sequencer
   import freq_dump_pkg::*;
#(
   parameter int NUM_PIXELS    = 3,
   parameter int WINDOW_CYCLES = 100000000,
   parameter int VALUE_WIDTH   = 32
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic                              start,
   input  logic                              stop,
   input  logic                              dump_req,
   input  logic                              irq_ack,
   input  logic [NUM_PIXELS*2*VALUE_WIDTH-1:0] f_values,
   output logic                              analyzer_enable,
   output logic                              analyzer_clear_n,
   output logic [VALUE_WIDTH-1:0]            dump_data,
   output logic                              dump_valid,
   input  logic                              dump_ready,
   output logic                              dump_last,
   output logic                              irq,
   output logic                              busy
);

`ifdef FREQ_DUMP_HEADER_EN
   localparam int HDR_WORDS = 1;
`else
   localparam int HDR_WORDS = 0;
`endif
   localparam int               NWORDS   = 2 * NUM_PIXELS + HDR_WORDS;
   localparam int               IDX_W    = $clog2(2 * NUM_PIXELS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
   localparam int               SNAP_W   = 2 * NUM_PIXELS * VALUE_WIDTH;

   logic [2:0]             state_r;
   logic [2:0]             state_nxt_s;
   logic [IDX_W-1:0]       idx_r;
   logic [SNAP_W-1:0]      snap_r;
   logic [FRAME_W-1:0]     frame_r;
   logic [VALUE_WIDTH-1:0] word_s;
   logic                   tc_s;
   logic                   hs_s;
   logic                   last_s;

   freq_window_timer #(
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) u_timer (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .load  (state_r == ST_CLEAR),
      .run   (state_r == ST_MEASURE),
      .tc    (tc_s)
   );

   assign hs_s   = (state_r == ST_DUMP) && dump_ready;
   assign last_s = (idx_r == LAST_IDX);

   // next-state decode; stop has priority over start in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (stop)          state_nxt_s = ST_IDLE;
            else if (start)    state_nxt_s = ST_CLEAR;
            else if (dump_req) state_nxt_s = ST_SNAPSHOT;
            else               state_nxt_s = ST_IDLE;
         end
         ST_CLEAR: begin
            if (stop) state_nxt_s = ST_IDLE;
            else      state_nxt_s = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (tc_s || stop || dump_req) state_nxt_s = ST_SNAPSHOT;
            else                          state_nxt_s = ST_MEASURE;
         end
         ST_SNAPSHOT: state_nxt_s = ST_DUMP;
         ST_DUMP: begin
            if (hs_s && last_s) state_nxt_s = ST_DONE;
            else                state_nxt_s = ST_DUMP;
         end
         ST_DONE: begin
            if (irq_ack) state_nxt_s = ST_IDLE;
            else         state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // state, snapshot, frame count and word index
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_r <= ST_IDLE;
         idx_r   <= '0;
         snap_r  <= '0;
         frame_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_SNAPSHOT) begin
            snap_r  <= f_values;
            frame_r <= frame_r + 16'd1;
            idx_r   <= '0;
         end else if (hs_s && !last_s) begin
            idx_r <= idx_r + IDX_W'(1);
         end else begin
            idx_r <= idx_r;
         end
      end
   end

   // word mux from the snapshot only, so live analyzer changes never leak out
   always_comb begin
      word_s = '0;
`ifdef FREQ_DUMP_HEADER_EN
      if (idx_r == '0) word_s = VALUE_WIDTH'(header_word(frame_r, 8'(NUM_PIXELS)));
      else             word_s = '0;
`endif
      for (int i = 0; i < 2 * NUM_PIXELS; i++) begin
         if (idx_r == IDX_W'(i + HDR_WORDS)) word_s = snap_r[i*VALUE_WIDTH +: VALUE_WIDTH];
         else                                word_s = word_s;
      end
   end

   assign analyzer_enable  = (state_r == ST_MEASURE);
   assign analyzer_clear_n = (state_r != ST_CLEAR);
   assign dump_valid       = (state_r == ST_DUMP);
   assign dump_last        = dump_valid && last_s;
   assign dump_data        = dump_valid ? word_s : '0;
   assign irq              = (state_r == ST_DONE);
   assign busy             = (state_r != ST_IDLE);

endmodule

// File: tb/tb_frequency_dump_sequencer.sv
// Randomized self-checking bench for frequency_dump_sequencer (NUM_PIXELS=3,
// WINDOW_CYCLES=8); expected dumps come from a transaction-level model.
module tb_frequency_dump_sequencer;

   localparam int NP = 3;
   localparam int W  = 8;
   localparam int VW = 32;
`ifdef FREQ_DUMP_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int NWORDS = 2 * NP + HDR;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, stop, dump_req, irq_ack, dump_ready;
   logic [NP*2*VW-1:0] f_values;
   logic              analyzer_enable, analyzer_clear_n;
   logic [VW-1:0]     dump_data;
   logic              dump_valid, dump_last, irq, busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   int frames  = 0;

   frequency_dump_sequencer #(
      .NUM_PIXELS    (NP),
      .WINDOW_CYCLES (W),
      .VALUE_WIDTH   (VW)
   ) dut (
      .s00_axi_aclk     (clk),
      .s00_axi_aresetn  (rst_n),
      .start            (start),
      .stop             (stop),
      .dump_req         (dump_req),
      .irq_ack          (irq_ack),
      .f_values         (f_values),
      .analyzer_enable  (analyzer_enable),
      .analyzer_clear_n (analyzer_clear_n),
      .dump_data        (dump_data),
      .dump_valid       (dump_valid),
      .dump_ready       (dump_ready),
      .dump_last        (dump_last),
      .irq              (irq),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_f;
      for (int i = 0; i < 2 * NP; i++) f_values[i*VW +: VW] = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, ".enable"},  analyzer_enable,  1'b0);
      check_value({tag, ".clear_n"}, analyzer_clear_n, 1'b1);
      check_value({tag, ".data"},    dump_data,        32'h0);
      check_value({tag, ".valid"},   dump_valid,       1'b0);
      check_value({tag, ".last"},    dump_last,        1'b0);
      check_value({tag, ".irq"},     irq,              1'b0);
      check_value({tag, ".busy"},    busy,             1'b0);
   endtask

   // kind 0: start-driven run, kind 1: dump_req from IDLE.
   // stop_at: MEASURE cycle (1-based) in which stop is raised, 0 = none.
   // rmode: 0 ready always high, 1 ready pattern 1-0-0-1, 2 random ready.
   // abort_at: word index at which reset is applied, -1 = none.
   task automatic run_cycle(input int kind, input int stop_at, input int rmode, input int abort_at);
      logic [31:0] exp_q[$];
      logic [3:0]  pat;
      logic [15:0] fc;
      int          k;
      int          c;
      logic        r;
      pat = 4'b1001;
      if (kind == 0) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         check_value("clear.clear_n", analyzer_clear_n, 1'b0);
         check_value("clear.enable",  analyzer_enable,  1'b0);
         check_value("clear.busy",    busy,             1'b1);
         rand_f();
         for (int m = 1; m <= W; m++) begin
            tick();
            check_value("measure.enable",  analyzer_enable,  1'b1);
            check_value("measure.clear_n", analyzer_clear_n, 1'b1);
            rand_f();
            if (m == stop_at) begin
               stop = 1'b1;
               break;
            end
         end
         tick();
      end else begin
         dump_req = 1'b1;
         tick();
      end
      stop     = 1'b0;
      dump_req = 1'b0;
      // now in SNAPSHOT: the values driven during this cycle are captured
      check_value("snap.enable",  analyzer_enable,  1'b0);
      check_value("snap.clear_n", analyzer_clear_n, 1'b1);
      check_value("snap.valid",   dump_valid,       1'b0);
      check_value("snap.busy",    busy,             1'b1);
      rand_f();
      frames++;
      fc = 16'(frames);
      if (HDR == 1) exp_q.push_back({fc, 8'(NP), 8'hA5});
      for (int p = 0; p < NP; p++) begin
         exp_q.push_back(f_values[(2*p)*VW +: VW]);
         exp_q.push_back(f_values[(2*p+1)*VW +: VW]);
      end
      k = 0;
      c = 0;
      while (k < NWORDS && c < 200) begin
         tick();
         rand_f();
         check_value("dump.valid", dump_valid, 1'b1);
         check_value("dump.data",  dump_data,  exp_q[k]);
         check_value("dump.last",  dump_last,  (k == NWORDS - 1));
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            frames     = 0;
            start      = 1'b0;
            stop       = 1'b0;
            dump_req   = 1'b0;
            irq_ack    = 1'b0;
            dump_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         case (rmode)
            0:       r = 1'b1;
            1:       r = pat[c % 4];
            default: r = 1'($urandom_range(0, 1));
         endcase
         dump_ready = r;
         start      = 1'($urandom_range(0, 1));
         stop       = 1'($urandom_range(0, 1));
         dump_req   = 1'($urandom_range(0, 1));
         irq_ack    = 1'($urandom_range(0, 1));
         if (r) k++;
         c++;
      end
      check_value("dump.timeout", (k == NWORDS), 1'b1);
      tick();
      start      = 1'b0;
      stop       = 1'b0;
      dump_req   = 1'b0;
      irq_ack    = 1'b0;
      dump_ready = 1'b0;
      check_value("done.irq",   irq,        1'b1);
      check_value("done.valid", dump_valid, 1'b0);
      check_value("done.last",  dump_last,  1'b0);
      check_value("done.busy",  busy,       1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_value("done.start_ignored", irq, 1'b1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_value("ack.irq",  irq,  1'b0);
      check_value("ack.busy", busy, 1'b0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      dump_req   = 1'b0;
      irq_ack    = 1'b0;
      dump_ready = 1'b0;
      f_values   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_value("idle.ack_ignored", busy, 1'b0);

      run_cycle(0, 0, 0, -1);
      run_cycle(0, 3, 0, -1);

      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check_value("startstop.busy",    busy,             1'b0);
      check_value("startstop.clear_n", analyzer_clear_n, 1'b1);
      tick();
      check_value("startstop.busy2",   busy,             1'b0);

      run_cycle(0, 0, 1, -1);
      run_cycle(1, 0, 2, -1);
      run_cycle(0, 0, 2, 3);
      run_cycle(0, 0, 0, -1);
      for (int n = 0; n < 6; n++) begin
         run_cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, W)), 2, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
